// File: rtl/stair_pkg.sv
// Shared widths, state encoding and default erase colour for the stair scheduler.
package stair_pkg;
    localparam int X_W   = 8;
    localparam int Y_W   = 7;
    localparam int COL_W = 3;

    localparam logic [COL_W-1:0] ERASE_COLOUR_DEFAULT = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        SELECT,
        ERASE,
        MOVE,
        DRAW,
        NEXT
    } state_e;
endpackage

// File: rtl/rect_painter.sv
// Walks a W x H rectangle in x-major raster order, one pixel per cycle after start.
module rect_painter
    import stair_pkg::*;
#(
    parameter int W = 40,
    parameter int H = 10
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic [X_W-1:0]   base_x_i,
    input  logic [Y_W-1:0]   base_y_i,
    input  logic [COL_W-1:0] colour_i,
    output logic [X_W-1:0]   x_o,
    output logic [Y_W-1:0]   y_o,
    output logic [COL_W-1:0] colour_o,
    output logic             plot_o,
    output logic             done_o
);
    localparam logic [X_W-1:0] COL_LAST = X_W'(W - 1);
    localparam logic [Y_W-1:0] ROW_LAST = Y_W'(H - 1);

    logic             busy_q, busy_d;
    logic [X_W-1:0]   col_q, col_d, bx_q, bx_d;
    logic [Y_W-1:0]   row_q, row_d, by_q, by_d;
    logic [COL_W-1:0] colour_q, colour_d;
    logic             last_pix;

    assign last_pix = (col_q == COL_LAST) && (row_q == ROW_LAST);

    // Counters are left at the last pixel when idle so the outputs hold.
    always_comb begin
        busy_d   = busy_q;
        col_d    = col_q;
        row_d    = row_q;
        bx_d     = bx_q;
        by_d     = by_q;
        colour_d = colour_q;
        if (start_i) begin
            busy_d   = 1'b1;
            col_d    = '0;
            row_d    = '0;
            bx_d     = base_x_i;
            by_d     = base_y_i;
            colour_d = colour_i;
        end else if (busy_q) begin
            if (last_pix) begin
                busy_d = 1'b0;
            end else if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            busy_q   <= 1'b0;
            col_q    <= '0;
            row_q    <= '0;
            bx_q     <= '0;
            by_q     <= '0;
            colour_q <= '0;
        end else begin
            busy_q   <= busy_d;
            col_q    <= col_d;
            row_q    <= row_d;
            bx_q     <= bx_d;
            by_q     <= by_d;
            colour_q <= colour_d;
        end
    end

    assign x_o      = bx_q + col_q;
    assign y_o      = by_q + row_q;
    assign colour_o = colour_q;
    assign plot_o   = busy_q;
    assign done_o   = busy_q && last_pix;
endmodule

// File: rtl/stair_scheduler.sv
// Per frame tick, erases, raises by one row and redraws every active stair through one painter.
module stair_scheduler
    import stair_pkg::*;
#(
    parameter int               NUM_STAIRS   = 4,
    parameter int               STAIR_W      = 40,
    parameter int               STAIR_H      = 10,
    parameter int               FRAME_TICKS  = 833333,
    parameter int               SPAWN_Y      = 110,
    parameter logic [COL_W-1:0] ERASE_COLOUR = ERASE_COLOUR_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  go,
    input  logic                  spawn_valid,
    input  logic [X_W-1:0]        spawn_x,
    input  logic [COL_W-1:0]      spawn_colour,
    output logic                  spawn_ready,
    output logic [X_W-1:0]        out_x,
    output logic [Y_W-1:0]        out_y,
    output logic [COL_W-1:0]      out_colour,
    output logic                  plot,
    output logic [NUM_STAIRS-1:0] active_mask,
    output logic                  frame_done
);
    localparam int IDX_W = $clog2(NUM_STAIRS);
    localparam int CNT_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FRAME_TICKS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_STAIRS - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d, free_idx;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pending_q, pending_d;
    logic               tick, spawn_fire, move_en;
    logic               paint_start, paint_done;
    logic [Y_W-1:0]     paint_base_y;
    logic [COL_W-1:0]   paint_colour;

    logic [X_W-1:0]     slot_x [NUM_STAIRS];
    logic [Y_W-1:0]     slot_y [NUM_STAIRS];
    logic [COL_W-1:0]   slot_c [NUM_STAIRS];
    logic [NUM_STAIRS-1:0] slot_fresh;
    logic [X_W-1:0]     cur_x;
    logic [Y_W-1:0]     cur_y;
    logic [COL_W-1:0]   cur_c;

    assign cur_x = slot_x[idx_q];
    assign cur_y = slot_y[idx_q];
    assign cur_c = slot_c[idx_q];

    assign tick        = (state_q != IDLE) && (cnt_q == '0);
    assign spawn_ready = (state_q == WAIT_TICK) && !(&active_mask);
    assign spawn_fire  = spawn_valid && spawn_ready;

    always_comb begin
        free_idx = '0;
        for (int i = NUM_STAIRS - 1; i >= 0; i--) begin
            if (!active_mask[i]) free_idx = IDX_W'(i);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_q != IDLE) cnt_d = tick ? CNT_RELOAD : cnt_q - 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        pending_d    = pending_q;
        paint_start  = 1'b0;
        paint_base_y = cur_y;
        paint_colour = cur_c;
        move_en      = 1'b0;
        frame_done   = 1'b0;
        // A tick that arrives while a frame is still being serviced is remembered once.
        if (tick && state_q != WAIT_TICK) pending_d = 1'b1;
        case (state_q)
            IDLE: if (go) state_d = WAIT_TICK;
            WAIT_TICK: begin
                if (tick || pending_q) begin
                    state_d   = SELECT;
                    idx_d     = '0;
                    pending_d = 1'b0;
                end
            end
            SELECT: begin
                if (!active_mask[idx_q]) begin
                    state_d = NEXT;
                end else if (slot_fresh[idx_q]) begin
                    state_d = MOVE;
                end else begin
                    state_d      = ERASE;
                    paint_start  = 1'b1;
                    paint_colour = ERASE_COLOUR;
                end
            end
            ERASE: if (paint_done) state_d = MOVE;
            MOVE: begin
                move_en = 1'b1;
                if (cur_y == '0) begin
                    state_d = NEXT;
                end else begin
                    state_d      = DRAW;
                    paint_start  = 1'b1;
                    paint_base_y = cur_y - 1'b1;
                end
            end
            DRAW: if (paint_done) state_d = NEXT;
            NEXT: begin
                if (idx_q == IDX_LAST) begin
                    frame_done = 1'b1;
                    state_d    = WAIT_TICK;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = SELECT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= CNT_RELOAD;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAIRS; gi++) begin : g_slot
            logic             act_q, fresh_q;
            logic [X_W-1:0]   x_q;
            logic [Y_W-1:0]   y_q;
            logic [COL_W-1:0] c_q;
            logic             load, service;

            assign load    = spawn_fire && (free_idx == IDX_W'(gi));
            assign service = move_en && (idx_q == IDX_W'(gi));

            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    act_q   <= 1'b0;
                    fresh_q <= 1'b0;
                    x_q     <= '0;
                    y_q     <= '0;
                    c_q     <= '0;
                end else if (load) begin
                    act_q   <= 1'b1;
                    fresh_q <= 1'b1;
                    x_q     <= spawn_x;
                    y_q     <= Y_W'(SPAWN_Y);
                    c_q     <= spawn_colour;
                end else if (service) begin
                    if (y_q == '0) begin
                        act_q <= 1'b0;
                    end else begin
                        y_q     <= y_q - 1'b1;
                        fresh_q <= 1'b0;
                    end
                end
            end

            assign active_mask[gi] = act_q;
            assign slot_fresh[gi]  = fresh_q;
            assign slot_x[gi]      = x_q;
            assign slot_y[gi]      = y_q;
            assign slot_c[gi]      = c_q;
        end
    endgenerate

    rect_painter #(
        .W(STAIR_W),
        .H(STAIR_H)
    ) u_painter (
        .clock    (clock),
        .reset_n  (reset_n),
        .start_i  (paint_start),
        .base_x_i (cur_x),
        .base_y_i (paint_base_y),
        .colour_i (paint_colour),
        .x_o      (out_x),
        .y_o      (out_y),
        .colour_o (out_colour),
        .plot_o   (plot),
        .done_o   (paint_done)
    );
endmodule

// File: tb/tb_stair_scheduler.sv
// Scoreboard bench: stimulus queues expected pixels and frame lengths, a monitor checks plots.
module tb_stair_scheduler;
    localparam int W = 4;
    localparam int H = 2;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset_n, go, spawn_valid;
    logic [7:0] spawn_x;
    logic [2:0] spawn_colour;
    logic       spawn_ready, plot, frame_done;
    logic [7:0] out_x;
    logic [6:0] out_y;
    logic [2:0] out_colour;
    logic [1:0] active_mask;

    logic       f_reset_n, f_go, f_spawn_valid;
    logic [7:0] f_spawn_x;
    logic [2:0] f_spawn_colour;
    logic       f_spawn_ready, f_plot, f_frame_done;
    logic [7:0] f_out_x;
    logic [6:0] f_out_y;
    logic [2:0] f_out_colour;
    logic [1:0] f_active_mask;

    stair_scheduler #(.NUM_STAIRS(2), .STAIR_W(W), .STAIR_H(H), .FRAME_TICKS(200), .SPAWN_Y(3)) u_dut (
        .clock(clock), .reset_n(reset_n), .go(go), .spawn_valid(spawn_valid),
        .spawn_x(spawn_x), .spawn_colour(spawn_colour), .spawn_ready(spawn_ready),
        .out_x(out_x), .out_y(out_y), .out_colour(out_colour), .plot(plot),
        .active_mask(active_mask), .frame_done(frame_done)
    );

    stair_scheduler #(.NUM_STAIRS(2), .STAIR_W(W), .STAIR_H(H), .FRAME_TICKS(10), .SPAWN_Y(3)) u_fast (
        .clock(clock), .reset_n(f_reset_n), .go(f_go), .spawn_valid(f_spawn_valid),
        .spawn_x(f_spawn_x), .spawn_colour(f_spawn_colour), .spawn_ready(f_spawn_ready),
        .out_x(f_out_x), .out_y(f_out_y), .out_colour(f_out_colour), .plot(f_plot),
        .active_mask(f_active_mask), .frame_done(f_frame_done)
    );

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    pix_t exp_q[$];
    int   dur_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic push_pix(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        pix_t p;
        p.x = x;
        p.y = y;
        p.c = c;
        exp_q.push_back(p);
    endtask

    task automatic push_rect(input logic [7:0] bx, input logic [6:0] by, input logic [2:0] c);
        for (int r = 0; r < H; r++)
            for (int k = 0; k < W; k++)
                push_pix(bx + 8'(k), by + 7'(r), c);
    endtask

    task automatic do_spawn(input logic [7:0] x, input logic [2:0] c);
        int n = 0;
        spawn_x      = x;
        spawn_colour = c;
        spawn_valid  = 1'b1;
        while (!spawn_ready && n < 500) begin
            @(negedge clock);
            n++;
        end
        check("spawn_ready_seen", int'(spawn_ready), 1);
        @(negedge clock);
        spawn_valid = 1'b0;
    endtask

    task automatic wait_frame();
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!frame_done && n < 1000);
        check("frame_done_seen", int'(frame_done), 1);
    endtask

    // Scoreboard monitor for the main instance.
    initial begin : monitor
        pix_t p;
        int   start_cyc = 0;
        bit   in_frame = 0;
        bit   prev_fd = 0;
        forever begin
            @(negedge clock);
            cyc++;
            if (plot) begin
                if (!in_frame) begin
                    in_frame  = 1;
                    start_cyc = cyc;
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pix_unexpected actual=(%0d,%0d,%0d) required=none", out_x, out_y, out_colour);
                end else begin
                    p = exp_q.pop_front();
                    check("pix_x", int'(out_x), int'(p.x));
                    check("pix_y", int'(out_y), int'(p.y));
                    check("pix_colour", int'(out_colour), int'(p.c));
                end
            end
            if (frame_done) begin
                check("frame_done_width", int'(prev_fd), 0);
                if (in_frame) begin
                    if (dur_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL frame_cycles actual=%0d required=none", cyc - start_cyc);
                    end else begin
                        check("frame_cycles", cyc - start_cyc, dur_q.pop_front());
                    end
                    in_frame = 0;
                end
            end
            if (!reset_n) in_frame = 0;
            prev_fd = frame_done;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        reset_n = 1'b0; go = 1'b0; spawn_valid = 1'b0; spawn_x = '0; spawn_colour = '0;
        f_reset_n = 1'b0; f_go = 1'b0; f_spawn_valid = 1'b0; f_spawn_x = '0; f_spawn_colour = '0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("rst_plot", int'(plot), 0);
        check("rst_spawn_ready", int'(spawn_ready), 0);
        check("rst_active_mask", int'(active_mask), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_out_x", int'(out_x), 0);
        check("rst_out_y", int'(out_y), 0);
        check("rst_out_colour", int'(out_colour), 0);

        go = 1'b1;
        @(negedge clock);
        go = 1'b0;
        check("wait_spawn_ready", int'(spawn_ready), 1);

        // Fresh stair: drawn straight at SPAWN_Y-1 with no erase.
        push_rect(8'd10, 7'd2, 3'b010);
        dur_q.push_back(10);
        do_spawn(8'd10, 3'b010);
        check("mask_after_spawn", int'(active_mask), 1);
        wait_frame();
        check("mask_frame1", int'(active_mask), 1);

        push_rect(8'd10, 7'd2, 3'b111);
        push_rect(8'd10, 7'd1, 3'b010);
        dur_q.push_back(19);
        wait_frame();

        push_rect(8'd10, 7'd1, 3'b111);
        push_rect(8'd10, 7'd0, 3'b010);
        dur_q.push_back(19);
        wait_frame();

        // Top row reached: erase only, slot retires.
        push_rect(8'd10, 7'd0, 3'b111);
        dur_q.push_back(11);
        wait_frame();
        check("mask_retired", int'(active_mask), 0);

        // Two fresh stairs, one wrapping past column 255.
        push_rect(8'd254, 7'd2, 3'b001);
        push_rect(8'd20, 7'd2, 3'b100);
        dur_q.push_back(19);
        do_spawn(8'd254, 3'b001);
        do_spawn(8'd20, 3'b100);
        check("mask_full", int'(active_mask), 3);
        spawn_valid = 1'b1; spawn_x = 8'd99; spawn_colour = 3'b101;
        @(negedge clock);
        check("ready_when_full", int'(spawn_ready), 0);
        wait_frame();
        spawn_valid = 1'b0;
        check("mask_full_after", int'(active_mask), 3);

        // Reset in the middle of the next draw.
        push_rect(8'd254, 7'd2, 3'b111);
        push_pix(8'd254, 7'd1, 3'b001);
        push_pix(8'd255, 7'd1, 3'b001);
        push_pix(8'd0, 7'd1, 3'b001);
        n = 0;
        for (int t = 0; t < 1000 && n < 11; t++) begin
            @(negedge clock);
            if (plot) n++;
        end
        check("plots_before_reset", n, 11);
        reset_n = 1'b0;
        @(negedge clock);
        check("midrst_plot", int'(plot), 0);
        check("midrst_mask", int'(active_mask), 0);
        check("midrst_frame_done", int'(frame_done), 0);
        check("midrst_out_x", int'(out_x), 0);
        reset_n = 1'b1;
        @(negedge clock);
        check("midrst_idle_ready", int'(spawn_ready), 0);
        repeat (5) @(negedge clock);
        check("pix_queue_empty", exp_q.size(), 0);
        check("dur_queue_empty", dur_q.size(), 0);

        // Short frame period: overrun ticks are held pending, next frame starts at once.
        f_reset_n = 1'b1;
        @(negedge clock);
        f_go = 1'b1;
        @(negedge clock);
        f_go = 1'b0;
        f_spawn_x = 8'd50; f_spawn_colour = 3'b011; f_spawn_valid = 1'b1;
        n = 0;
        while (!f_spawn_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        f_spawn_valid = 1'b0;
        check("fast_mask", int'(f_active_mask), 1);
        for (int fr = 0; fr < 2; fr++) begin
            n = 0;
            do begin
                @(negedge clock);
                n++;
            end while (!f_frame_done && n < 200);
            check("fast_frame_done_seen", int'(f_frame_done), 1);
            n = 0;
            do begin
                @(negedge clock);
                n++;
            end while (!f_plot && n < 200);
            check("pending_restart_gap", n, 3);
            check("fast_erase_x", int'(f_out_x), 50);
            check("fast_erase_y", int'(f_out_y), 2 - fr);
            check("fast_erase_colour", int'(f_out_colour), 7);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
